// File: rtl/ticket_vendor_change.sv
// Ticket vending controller: accumulates coin credit, issues a ticket at PRICE, returns greedy change or refunds.
// Latency: credit updates one edge after a coin; ticket the edge a coin reaches PRICE; change coins follow one per cycle.
// Backpressure: busy is high in VEND/CHANGE; coins and cancel are ignored then and must be held upstream.
module ticket_vendor_change #(
    parameter int PRICE       = 15,
    parameter int CREDIT_W    = 6,
    parameter int VAL_PENNY   = 1,
    parameter int VAL_NICKEL  = 5,
    parameter int VAL_DIME    = 10,
    parameter int VAL_QUARTER = 25
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin,
    input  logic                cancel,
    output logic                ticket,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_VEND    = 2'd1,
        S_CHANGE  = 2'd2
    } state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] PENNY_C   = CREDIT_W'(VAL_PENNY);
    localparam logic [CREDIT_W-1:0] NICKEL_C  = CREDIT_W'(VAL_NICKEL);
    localparam logic [CREDIT_W-1:0] DIME_C    = CREDIT_W'(VAL_DIME);
    localparam logic [CREDIT_W-1:0] QUARTER_C = CREDIT_W'(VAL_QUARTER);

    localparam logic [1:0] CODE_PENNY  = 2'b00;
    localparam logic [1:0] CODE_NICKEL = 2'b01;
    localparam logic [1:0] CODE_DIME   = 2'b10;

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic [CREDIT_W-1:0]   coin_val;
    logic [CREDIT_W-1:0]   sum;
    logic [1:0]            chg_code;
    logic [CREDIT_W-1:0]   chg_val;
    logic [CREDIT_W-1:0]   chg_rem;

    // Value of the coin being offered by the acceptor.
    always_comb begin
        coin_val = PENNY_C;
        case (coin)
            2'b00:   coin_val = PENNY_C;
            2'b01:   coin_val = NICKEL_C;
            2'b10:   coin_val = DIME_C;
            default: coin_val = QUARTER_C;
        endcase
    end

    assign sum = credit_q + coin_val;

    // Greedy change selection from the credit still owed; quarters are never paid out.
    always_comb begin
        chg_code = CODE_PENNY;
        chg_val  = PENNY_C;
        if (credit_q >= DIME_C) begin
            chg_code = CODE_DIME;
            chg_val  = DIME_C;
        end else if (credit_q >= NICKEL_C) begin
            chg_code = CODE_NICKEL;
            chg_val  = NICKEL_C;
        end
    end

    assign chg_rem = credit_q - chg_val;

    // Next-state and next-credit decode; cancel beats a coin offered in the same cycle.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        case (state_q)
            S_COLLECT: begin
                if (cancel) begin
                    if (credit_q != '0) begin
                        state_d = S_CHANGE;
                    end
                end else if (coin_valid) begin
                    if (sum >= PRICE_C) begin
                        credit_d = sum - PRICE_C;
                        state_d  = S_VEND;
                    end else begin
                        credit_d = sum;
                    end
                end
            end
            S_VEND: begin
                state_d = (credit_q != '0) ? S_CHANGE : S_COLLECT;
            end
            S_CHANGE: begin
                credit_d = chg_rem;
                if (chg_rem == '0) begin
                    state_d = S_COLLECT;
                end
            end
            default: begin
                state_d  = S_COLLECT;
                credit_d = '0;
            end
        endcase
    end

    // State and credit registers; reset discards any change still owed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_COLLECT;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
        end
    end

    // Moore outputs decoded from state, and from credit while paying change.
    always_comb begin
        ticket       = (state_q == S_VEND);
        change_valid = (state_q == S_CHANGE);
        change_coin  = (state_q == S_CHANGE) ? chg_code : CODE_PENNY;
        busy         = (state_q != S_COLLECT);
        credit       = credit_q;
    end

endmodule

// File: tb/tb_ticket_vendor_change.sv
// Bench for ticket_vendor_change: default-price vector table plus reset and PRICE=30 sequences.
// Inputs are driven 1 ns after the rising edge and outputs are sampled 1 ns after it.
// Expected values are hand-computed from the coin arithmetic.
module tb_ticket_vendor_change;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin = 2'b00;
    logic       cancel = 1'b0;
    logic       ticket;
    logic       change_valid;
    logic [1:0] change_coin;
    logic       busy;
    logic [5:0] credit;

    logic       cv30 = 1'b0;
    logic [1:0] coin30 = 2'b00;
    logic       cancel30 = 1'b0;
    logic       ticket30;
    logic       change_valid30;
    logic [1:0] change_coin30;
    logic       busy30;
    logic [5:0] credit30;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ticket_vendor_change u_dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin         (coin),
        .cancel       (cancel),
        .ticket       (ticket),
        .change_valid (change_valid),
        .change_coin  (change_coin),
        .busy         (busy),
        .credit       (credit)
    );

    ticket_vendor_change #(.PRICE(30), .CREDIT_W(6)) u_dut30 (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (cv30),
        .coin         (coin30),
        .cancel       (cancel30),
        .ticket       (ticket30),
        .change_valid (change_valid30),
        .change_coin  (change_coin30),
        .busy         (busy30),
        .credit       (credit30)
    );

    typedef struct {
        string      nm;
        logic       cv;
        logic [1:0] c;
        logic       ca;
        logic       t;
        logic       chv;
        logic [1:0] cc;
        logic       b;
        logic [5:0] cr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string nm, input logic cv, input logic [1:0] c,
                                input logic ca, input logic t, input logic chv,
                                input logic [1:0] cc, input logic b, input logic [5:0] cr);
        vec_t v;
        v.nm = nm; v.cv = cv; v.c = c; v.ca = ca;
        v.t = t; v.chv = chv; v.cc = cc; v.b = b; v.cr = cr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string nm, input logic t, input logic chv,
                           input logic [1:0] cc, input logic b, input logic [5:0] cr);
        chk({nm, ".ticket"},       32'(ticket),       32'(t));
        chk({nm, ".change_valid"}, 32'(change_valid), 32'(chv));
        chk({nm, ".change_coin"},  32'(change_coin),  32'(cc));
        chk({nm, ".busy"},         32'(busy),         32'(b));
        chk({nm, ".credit"},       32'(credit),       32'(cr));
    endtask

    task automatic drive(input logic cv, input logic [1:0] c, input logic ca);
        coin_valid = cv;
        coin       = c;
        cancel     = ca;
        @(posedge clk);
        #1;
    endtask

    task automatic drive30(input logic cv, input logic [1:0] c);
        cv30   = cv;
        coin30 = c;
        @(posedge clk);
        #1;
    endtask

    localparam logic [1:0] P = 2'b00, N = 2'b01, D = 2'b10, Q = 2'b11;

    initial begin
        // inputs cv coin cancel | expected ticket chv cc busy credit
        vecs.push_back(mk("mix_penny",   1, P, 0,  0, 0, P, 0, 6'd1));
        vecs.push_back(mk("mix_nickel",  1, N, 0,  0, 0, P, 0, 6'd6));
        vecs.push_back(mk("mix_penny2",  1, P, 0,  0, 0, P, 0, 6'd7));
        vecs.push_back(mk("mix_dime",    1, D, 0,  1, 0, P, 1, 6'd2));
        vecs.push_back(mk("mix_chg1",    0, P, 0,  0, 1, P, 1, 6'd2));
        vecs.push_back(mk("mix_chg2",    0, P, 0,  0, 1, P, 1, 6'd1));
        vecs.push_back(mk("mix_done",    0, P, 0,  0, 0, P, 0, 6'd0));
        vecs.push_back(mk("exact_nick",  1, N, 0,  0, 0, P, 0, 6'd5));
        vecs.push_back(mk("exact_dime",  1, D, 0,  1, 0, P, 1, 6'd0));
        vecs.push_back(mk("exact_done",  0, P, 0,  0, 0, P, 0, 6'd0));
        vecs.push_back(mk("q_vend",      1, Q, 0,  1, 0, P, 1, 6'd10));
        vecs.push_back(mk("q_chg",       0, P, 0,  0, 1, D, 1, 6'd10));
        vecs.push_back(mk("q_done",      0, P, 0,  0, 0, P, 0, 6'd0));
        vecs.push_back(mk("ref_dime",    1, D, 0,  0, 0, P, 0, 6'd10));
        vecs.push_back(mk("ref_penny",   1, P, 0,  0, 0, P, 0, 6'd11));
        vecs.push_back(mk("ref_cancel",  0, P, 1,  0, 1, D, 1, 6'd11));
        vecs.push_back(mk("ref_chg2",    0, P, 0,  0, 1, P, 1, 6'd1));
        vecs.push_back(mk("ref_done",    0, P, 0,  0, 0, P, 0, 6'd0));
        vecs.push_back(mk("prio_nick",   1, N, 0,  0, 0, P, 0, 6'd5));
        vecs.push_back(mk("prio_both",   1, Q, 1,  0, 1, N, 1, 6'd5));
        vecs.push_back(mk("prio_done",   0, P, 0,  0, 0, P, 0, 6'd0));
        vecs.push_back(mk("cancel_zero", 0, P, 1,  0, 0, P, 0, 6'd0));
        vecs.push_back(mk("lock_d1",     1, D, 0,  0, 0, P, 0, 6'd10));
        vecs.push_back(mk("lock_d2",     1, D, 0,  1, 0, P, 1, 6'd5));
        vecs.push_back(mk("lock_vend",   1, D, 0,  0, 1, N, 1, 6'd5));
        vecs.push_back(mk("lock_chg",    1, D, 0,  0, 0, P, 0, 6'd0));
        vecs.push_back(mk("lock_resume", 1, D, 0,  0, 0, P, 0, 6'd10));
        vecs.push_back(mk("lock_cancel", 0, P, 1,  0, 1, D, 1, 6'd10));
        vecs.push_back(mk("lock_done",   0, P, 0,  0, 0, P, 0, 6'd0));

        // Asynchronous reset asserted mid-cycle clears outputs without a clock edge.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_all("reset", 0, 0, P, 0, 6'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].cv, vecs[i].c, vecs[i].ca);
            chk_all(vecs[i].nm, vecs[i].t, vecs[i].chv, vecs[i].cc, vecs[i].b, vecs[i].cr);
        end

        // Dime plus dime, then reset in the middle of paying out the nickel.
        drive(1, D, 0);
        chk_all("dd_first", 0, 0, P, 0, 6'd10);
        drive(1, D, 0);
        chk_all("dd_vend", 1, 0, P, 1, 6'd5);
        drive(0, P, 0);
        chk_all("dd_chg", 0, 1, N, 1, 6'd5);
        #3;
        rst = 1'b1;
        #1;
        chk_all("dd_rst", 0, 0, P, 0, 6'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(0, P, 0);
            chk_all($sformatf("dd_after%0d", k), 0, 0, P, 0, 6'd0);
        end

        // PRICE=30 instance: two quarters give a ticket and two dimes of change.
        drive30(1, Q);
        chk("p30_q1.credit", 32'(credit30), 32'd25);
        chk("p30_q1.busy",   32'(busy30),   32'd0);
        drive30(1, Q);
        chk("p30_vend.ticket", 32'(ticket30), 32'd1);
        chk("p30_vend.credit", 32'(credit30), 32'd20);
        drive30(0, P);
        chk("p30_c1.valid",  32'(change_valid30), 32'd1);
        chk("p30_c1.coin",   32'(change_coin30),  32'(D));
        chk("p30_c1.credit", 32'(credit30),       32'd20);
        drive30(0, P);
        chk("p30_c2.valid",  32'(change_valid30), 32'd1);
        chk("p30_c2.coin",   32'(change_coin30),  32'(D));
        chk("p30_c2.credit", 32'(credit30),       32'd10);
        drive30(0, P);
        chk("p30_done.valid",  32'(change_valid30), 32'd0);
        chk("p30_done.busy",   32'(busy30),         32'd0);
        chk("p30_done.credit", 32'(credit30),       32'd0);
        chk("p30_done.cancel", 32'(cancel30),       32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
